pipe_stage: RTL

Parametrised pipeline stage register and successor to the fixed-field inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries an opaque WIDTH-bit payload (packed control, data and rd fields) between two processor stages with a valid/ready handshake, synchronous flush, an optional skid slot and a saturating stall counter. One instance sits between each pair of pipeline stages. Hazard and branch logic drive flush; downstream stall logic drives out_ready.

---
 rtl/pipe_pkg.sv | 22 ++
 rtl/pipe_slot.sv | 37 +++
 rtl/pipe_stage.sv | 107 ++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
`default_nettype none
// pipe_pkg: shared occupancy codes, stage-bundle widths and the EX/MEM bundle layout.
package pipe_pkg;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_FULL  = 2'd2;

  localparam int IF_ID_W  = 64;
  localparam int ID_EX_W  = 118;
  localparam int EX_MEM_W = 76;
  localparam int MEM_WB_W = 70;

  typedef struct packed {
    logic [6:0]  ctrl;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic [4:0]  rd;
  } ex_mem_t;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/pipe_slot.sv
`default_nettype none
// pipe_slot: one valid+data register; clear beats load and leaves the data untouched.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int               WIDTH       = EX_MEM_W,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_load,
  input  logic             i_clear,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_data  <= RESET_VALUE;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule : pipe_slot
`default_nettype wire

// File: rtl/pipe_stage.sv
`default_nettype none
// pipe_stage: valid/ready pipeline register with flush and saturating stall counter.
// Define PIPE_STAGE_SKID_EN to add a skid slot and a registered in_ready.
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int               WIDTH       = EX_MEM_W,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               CNT_WIDTH   = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [1:0]           occupancy,
  output logic [CNT_WIDTH-1:0] stall_count
);

  logic             w_in_xfer;
  logic             w_valid_q;
  logic [WIDTH-1:0] w_data_q;
  logic             w_skid_valid_q;
  logic             w_main_load;
  logic             w_main_clear;
  logic [WIDTH-1:0] w_main_data;
  logic [CNT_WIDTH-1:0] r_stall_count;

  assign w_in_xfer = in_valid && in_ready;

`ifdef PIPE_STAGE_SKID_EN
  logic             w_skid_load;
  logic             w_skid_clear;
  logic [WIDTH-1:0] w_skid_data;
  logic             r_in_ready;

  // Main refills from skid first; new data only lands in main when skid is empty.
  assign w_main_load  = (w_skid_valid_q && out_ready) ||
                        (!w_skid_valid_q && w_in_xfer && (!w_valid_q || out_ready));
  assign w_main_data  = w_skid_valid_q ? w_skid_data : in_data;
  assign w_skid_load  = !w_skid_valid_q && w_in_xfer && w_valid_q && !out_ready;
  assign w_skid_clear = flush || (w_skid_valid_q && out_ready);

  pipe_slot #(
    .WIDTH      (WIDTH),
    .RESET_VALUE(RESET_VALUE)
  ) u_skid (
    .clock  (clock),
    .reset  (reset),
    .i_load (w_skid_load),
    .i_clear(w_skid_clear),
    .i_data (in_data),
    .o_valid(w_skid_valid_q),
    .o_data (w_skid_data)
  );

  // Shadow of the skid slot's next valid, kept so in_ready comes straight off a flop.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_in_ready <= 1'b1;
    end else begin
      r_in_ready <= !(!w_skid_clear && (w_skid_load || w_skid_valid_q));
    end
  end

  assign in_ready = r_in_ready;
`else
  assign w_skid_valid_q = 1'b0;
  assign w_main_load    = w_in_xfer;
  assign w_main_data    = in_data;
  assign in_ready       = !w_valid_q || out_ready;
`endif

  assign w_main_clear = flush || (out_ready && !w_main_load);

  pipe_slot #(
    .WIDTH      (WIDTH),
    .RESET_VALUE(RESET_VALUE)
  ) u_main (
    .clock  (clock),
    .reset  (reset),
    .i_load (w_main_load),
    .i_clear(w_main_clear),
    .i_data (w_main_data),
    .o_valid(w_valid_q),
    .o_data (w_data_q)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_stall_count <= '0;
    end else if (w_valid_q && !out_ready && (r_stall_count != '1)) begin
      r_stall_count <= r_stall_count + 1'b1;
    end
  end

  assign out_valid   = w_valid_q;
  assign out_data    = w_data_q;
  assign occupancy   = {1'b0, w_valid_q} + {1'b0, w_skid_valid_q};
  assign stall_count = r_stall_count;

endmodule : pipe_stage
`default_nettype wire
